mac_lane_engine: RTL and testbench

//  Parametrised multi-lane successor to the single multiply/bias/ReLU datapath in the MLP pipeline.
//  A neuron value broadcast on each beat is multiplied by one signed weight per lane and accumulated,
//  so LANES output neurons are computed at once.
//  On job end each lane adds its bias, rescales, applies optional ReLU, saturates, and presents the

---
 rtl/mac_lane_engine.sv | 128 ++++++++++++
 tb/tb_mac_lane_engine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mac_lane_engine.sv
// Multi-lane multiply/accumulate engine: broadcast neuron x per-lane weight,
// then bias, rescale, optional ReLU and saturation, returned under valid/ready.
module mac_lane_engine #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned NEURON_W  = 16,
  parameter int unsigned WEIGHT_W  = 8,
  parameter int unsigned BIAS_W    = 8,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned FRAC_BITS = 0,
  parameter int unsigned LEN_W     = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LEN_W-1:0]          in_len,
  input  logic                      relu_en,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NEURON_W-1:0]       neuron_val,
  input  logic [LANES*WEIGHT_W-1:0] weight_vals,
  input  logic [LANES*BIAS_W-1:0]   bias_vals,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*OUT_W-1:0]    out_vals,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned PROD_W = NEURON_W + WEIGHT_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FINAL, S_OUTPUT} state_e;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         cnt_q;
  logic                     relu_q;
  logic [LANES*ACC_W-1:0]   acc_q;
  logic [LANES*ACC_W-1:0]   acc_sum;
  logic [LANES*OUT_W-1:0]   out_q;
  logic [LANES*OUT_W-1:0]   fin_vals;
  logic                     done_q;
  logic                     beat;
  logic                     last_beat;

  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_OUTPUT);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_vals  = out_q;
  assign beat      = in_valid && in_ready;
  // Compare one bit wider so in_len = 2^LEN_W-1 never sees the count wrap.
  assign last_beat = (({1'b0, cnt_q} + 1'b1) == {1'b0, len_q});

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_cur;
    logic signed [SUM_W-1:0]  bias_al;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  shr;
    logic signed [OUT_W-1:0]  res;

    assign acc_cur = acc_q[l*ACC_W +: ACC_W];
    assign prod    = PROD_W'($signed(neuron_val)) *
                     PROD_W'($signed(weight_vals[l*WEIGHT_W +: WEIGHT_W]));
    assign acc_sum[l*ACC_W +: ACC_W] = acc_cur + ACC_W'(prod);
    assign bias_al = SUM_W'($signed(bias_vals[l*BIAS_W +: BIAS_W])) <<< FRAC_BITS;
    assign sum     = SUM_W'(acc_cur) + bias_al;
    assign shr     = sum >>> FRAC_BITS;

    always_comb begin
      res = shr[OUT_W-1:0];
      if (relu_q && shr[SUM_W-1]) begin
        res = '0;
      end else if (shr > SAT_MAX) begin
        res = {1'b0, {(OUT_W-1){1'b1}}};
      end else if (shr < SAT_MIN) begin
        res = {1'b1, {(OUT_W-1){1'b0}}};
      end
    end

    assign fin_vals[l*OUT_W +: OUT_W] = res;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (in_len == '0) ? S_FINAL : S_ACCUM;
      S_ACCUM:  if (beat && last_beat) state_d = S_FINAL;
      S_FINAL:  state_d = S_OUTPUT;
      S_OUTPUT: if (out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      relu_q  <= 1'b0;
      acc_q   <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_OUTPUT) && out_ready;
      case (state_q)
        S_IDLE: if (start) begin
          len_q  <= in_len;
          relu_q <= relu_en;
          acc_q  <= '0;
          cnt_q  <= '0;
        end
        S_ACCUM: if (beat) begin
          acc_q <= acc_sum;
          cnt_q <= cnt_q + 1'b1;
        end
        S_FINAL: out_q <= fin_vals;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_lane_engine.sv
// Directed bench for mac_lane_engine with two lanes: table of jobs plus
// hand-written stall/abort sequences.
module tb_mac_lane_engine;

  logic        clk = 1'b0;
  logic        reset, start, relu_en, in_valid, out_ready;
  logic [11:0] in_len;
  logic        in_ready, out_valid, busy, done;
  logic [15:0] neuron_val;
  logic [15:0] weight_vals;
  logic [15:0] bias_vals;
  logic [31:0] out_vals;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string name;
    int    len;
    bit    relu;
    int    nv[4];
    int    w0[4];
    int    w1[4];
    int    b0;
    int    b1;
    int    e0;
    int    e1;
  } job_t;

  job_t jobs[4];

  always #5 clk = ~clk;

  mac_lane_engine #(.LANES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .in_len(in_len), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .neuron_val(neuron_val),
    .weight_vals(weight_vals), .bias_vals(bias_vals), .out_valid(out_valid),
    .out_ready(out_ready), .out_vals(out_vals), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint lane(input int i);
    logic signed [15:0] v;
    v = out_vals[i*16 +: 16];
    return longint'(v);
  endfunction

  task automatic run_job(input job_t j);
    bias_vals = {8'(j.b1), 8'(j.b0)};
    in_len    = 12'(j.len);
    relu_en   = j.relu;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    chk({j.name, " busy"}, busy, 1);
    for (int i = 0; i < j.len; i++) begin
      in_valid    = 1'b1;
      neuron_val  = 16'(j.nv[i]);
      weight_vals = {8'(j.w1[i]), 8'(j.w0[i])};
      chk({j.name, " in_ready"}, in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    chk({j.name, " final out_valid"}, out_valid, 0);
    chk({j.name, " final in_ready"}, in_ready, 0);
    tick();
    chk({j.name, " out_valid"}, out_valid, 1);
    chk({j.name, " out in_ready"}, in_ready, 0);
    chk({j.name, " out0"}, lane(0), j.e0);
    chk({j.name, " out1"}, lane(1), j.e1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({j.name, " done"}, done, 1);
    chk({j.name, " out_valid drop"}, out_valid, 0);
    chk({j.name, " idle"}, busy, 0);
    tick();
    chk({j.name, " done pulse"}, done, 0);
  endtask

  initial begin
    int waited;
    jobs[0] = '{"t1", 3, 1'b0, '{1, 2, 3, 0}, '{2, 2, 2, 0}, '{-1, -1, -1, 0}, 5, 0, 17, -6};
    jobs[1] = '{"t2", 3, 1'b1, '{1, 2, 3, 0}, '{2, 2, 2, 0}, '{-1, -1, -1, 0}, 5, 0, 17, 0};
    jobs[2] = '{"t3", 4, 1'b0, '{32767, 32767, 32767, 32767}, '{127, 127, 127, 127},
                '{-128, -128, -128, -128}, 0, 0, 32767, -32768};
    jobs[3] = '{"t5", 0, 1'b1, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 5, -3, 5, 0};

    reset = 1'b1; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_len = '0; neuron_val = '0; weight_vals = '0; bias_vals = '0;
    tick();
    tick();
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_vals", out_vals, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    reset = 1'b0;
    tick();

    for (int k = 0; k < 4; k++) run_job(jobs[k]);

    // Gapped input, stray starts, in_valid outside ACCUM, stalled output.
    bias_vals = {8'sd0, 8'sd5};
    in_len    = 12'd3;
    relu_en   = 1'b0;
    start     = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0; neuron_val = 16'd999; weight_vals = 16'h7f7f; start = 1'b1;
      tick();
      in_valid = 1'b1; neuron_val = 16'(i + 1); weight_vals = {8'hff, 8'd2}; start = 1'b0;
      tick();
    end
    in_valid = 1'b1; neuron_val = 16'd500;
    waited = 0;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    chk("t4 out_valid timeout", out_valid, 1);
    for (int c = 0; c < 5; c++) begin
      start = c[0];
      tick();
      chk("t4 stall out0", lane(0), 17);
      chk("t4 stall out1", lane(1), -6);
      chk("t4 stall valid", out_valid, 1);
      chk("t4 stall done", done, 0);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t4 done", done, 1);
    // start while done is high must be accepted immediately
    run_job(jobs[0]);

    // Abort a job with reset after two beats, then rerun cleanly.
    bias_vals = {8'sd0, 8'sd5};
    in_len = 12'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; neuron_val = 16'd1000; weight_vals = {8'd50, 8'd50};
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("t6 rst busy", busy, 0);
    chk("t6 rst in_ready", in_ready, 0);
    chk("t6 rst out_valid", out_valid, 0);
    chk("t6 rst out_vals", out_vals, 0);
    chk("t6 rst done", done, 0);
    reset = 1'b0;
    tick();
    run_job(jobs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
